// File: rtl/mux_pipe_nway.sv
// N-way, WIDTH-bit operand select mux feeding a registered two-entry valid/ready skid stage.
// Define SEL_ERR_EN to add the sticky out-of-range select flag on sel_err_o.
module mux_pipe_nway #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NUM   = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]     select_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [WIDTH-1:0]     data_o,
    output logic                 valid_o,
    input  logic                 ready_i
`ifdef SEL_ERR_EN
    ,
    output logic                 sel_err_o
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [WIDTH-1:0] sel_val;
    logic             ready_q, ready_d;
    logic             acc, drn;

    // Out-of-range selects fall through to zero.
    always_comb begin
        sel_val = '0;
        for (int unsigned k = 0; k < NUM; k++) begin
            if (32'(select_i) == k) begin
                sel_val = data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign acc = valid_i & ready_q;
    assign drn = valid_o & ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (acc) begin
                    main_d  = sel_val;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (acc && drn) begin
                    main_d = sel_val;
                end else if (acc) begin
                    skid_d  = sel_val;
                    state_d = StFull;
                end else if (drn) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (drn) begin
                    main_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // ready comes from its own flop so ready_i never reaches ready_o combinationally.
    assign ready_d = (state_d != StFull);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign valid_o = (state_q != StEmpty);
    assign data_o  = main_q;
    assign ready_o = ready_q;

`ifdef SEL_ERR_EN
    logic sel_err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel_err_q <= 1'b0;
        end else if (acc && (32'(select_i) >= NUM)) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err_o = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_pipe_nway.sv
// Bench for mux_pipe_nway: directed scenarios on a 4-way instance, select range and
// randomized scoreboard run on a 5-way instance.
module tb_mux_pipe_nway;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [4*W-1:0] a_data;
    logic [1:0]     a_sel;
    logic           a_valid, a_ready_in, a_ready, a_valid_o;
    logic [W-1:0]   a_dout;
    logic           a_err;

    logic [5*W-1:0] b_data;
    logic [2:0]     b_sel;
    logic           b_valid, b_ready_in, b_ready, b_valid_o;
    logic [W-1:0]   b_dout;
    logic           b_err;

    mux_pipe_nway #(.WIDTH(W), .NUM(4), .SEL_W(2)) u_dut4 (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .data_i   (a_data),
        .select_i (a_sel),
        .valid_i  (a_valid),
        .ready_o  (a_ready),
        .data_o   (a_dout),
        .valid_o  (a_valid_o),
        .ready_i  (a_ready_in)
`ifdef SEL_ERR_EN
        ,
        .sel_err_o(a_err)
`endif
    );

    mux_pipe_nway #(.WIDTH(W), .NUM(5), .SEL_W(3)) u_dut5 (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .data_i   (b_data),
        .select_i (b_sel),
        .valid_i  (b_valid),
        .ready_o  (b_ready),
        .data_o   (b_dout),
        .valid_o  (b_valid_o),
        .ready_i  (b_ready_in)
`ifdef SEL_ERR_EN
        ,
        .sel_err_o(b_err)
`endif
    );

`ifndef SEL_ERR_EN
    assign a_err = 1'b0;
    assign b_err = 1'b0;
`endif

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (a_valid_o !== 1'b0 || a_dout !== '0 || a_ready !== 1'b1 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL reset4: valid=%b data=%h ready=%b err=%b, want 0/0/1/0",
                     a_valid_o, a_dout, a_ready, a_err);
        end
        checks++;
        if (b_valid_o !== 1'b0 || b_dout !== '0 || b_ready !== 1'b1 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL reset5: valid=%b data=%h ready=%b err=%b, want 0/0/1/0",
                     b_valid_o, b_dout, b_ready, b_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [W-1:0] want;
        a_ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= 4) begin
                want = 32'h11 * (i);
                checks++;
                if (a_valid_o !== 1'b1 || a_dout !== want) begin
                    errors++;
                    $display("FAIL stream[%0d]: valid=%b data=%h, want 1/%h", i, a_valid_o, a_dout, want);
                end
            end else if (i == 5) begin
                checks++;
                if (a_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_end: valid=%b, want 0", a_valid_o);
                end
            end
            checks++;
            if (a_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready[%0d]: ready=%b, want 1", i, a_ready);
            end
            if (i < 4) begin
                a_data = {$urandom, $urandom, $urandom, $urandom};
                a_data[i*W +: W] = 32'h11 * (i + 1);
                a_sel   = 2'(i);
                a_valid = 1'b1;
            end else begin
                a_valid = 1'b0;
            end
        end
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        a_ready_in = 1'b0;
        a_data = {$urandom, $urandom, $urandom, $urandom};
        a_data[0 +: W] = 32'hA;
        a_sel = 2'd0;
        a_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (a_valid_o !== 1'b1 || a_dout !== 32'hA || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_a: valid=%b data=%h ready=%b, want 1/a/1", a_valid_o, a_dout, a_ready);
        end
        a_data = {$urandom, $urandom, $urandom, $urandom};
        a_data[2*W +: W] = 32'hB;
        a_sel = 2'd2;
        @(negedge clk);
        checks++;
        if (a_valid_o !== 1'b1 || a_dout !== 32'hA || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: valid=%b data=%h ready=%b, want 1/a/0", a_valid_o, a_dout, a_ready);
        end
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_valid_o !== 1'b1 || a_dout !== 32'hA || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: valid=%b data=%h ready=%b, want 1/a/0", a_valid_o, a_dout, a_ready);
        end
        a_ready_in = 1'b1;
        @(negedge clk);
        checks++;
        if (a_valid_o !== 1'b1 || a_dout !== 32'hB || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_b: valid=%b data=%h ready=%b, want 1/b/1", a_valid_o, a_dout, a_ready);
        end
        @(negedge clk);
        checks++;
        if (a_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: valid=%b, want 0", a_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_ready_in = 1'b0;
        a_data = {$urandom, $urandom, $urandom, $urandom};
        a_data[1*W +: W] = 32'h55;
        a_data[3*W +: W] = 32'h66;
        a_sel = 2'd1;
        a_valid = 1'b1;
        @(negedge clk);
        a_sel = 2'd3;
        @(negedge clk);
        a_valid = 1'b0;
        checks++;
        if (a_ready !== 1'b0 || a_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_fill: ready=%b valid=%b, want 0/1", a_ready, a_valid_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_valid_o !== 1'b0 || a_dout !== '0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: valid=%b data=%h ready=%b, want 0/0/1", a_valid_o, a_dout, a_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a_ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (a_valid_o !== 1'b0 || a_dout !== '0 || a_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_stale[%0d]: valid=%b data=%h ready=%b, want 0/0/1",
                         i, a_valid_o, a_dout, a_ready);
            end
        end
    endtask

    task automatic test_sel_range();
        logic [W-1:0] want;
        b_ready_in = 1'b1;
        @(negedge clk);
        b_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b_sel = 3'd6;
        b_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (b_valid_o !== 1'b1 || b_dout !== '0) begin
            errors++;
            $display("FAIL sel_oor: valid=%b data=%h, want 1/0", b_valid_o, b_dout);
        end
`ifdef SEL_ERR_EN
        checks++;
        if (b_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_set: err=%b, want 1", b_err);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            b_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
            want = b_data[4*W +: W];
            b_sel = 3'd4;
            @(negedge clk);
            checks++;
            if (b_valid_o !== 1'b1 || b_dout !== want || b_err !== (`ifdef SEL_ERR_EN 1'b1 `else 1'b0 `endif)) begin
                errors++;
                $display("FAIL sel_last[%0d]: valid=%b data=%h err=%b, want 1/%h/sticky",
                         i, b_valid_o, b_dout, b_err, want);
            end
        end
        b_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (b_err !== 1'b0) begin
            errors++;
            $display("FAIL sel_err_clr: err=%b, want 0", b_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        logic [W-1:0] chans[5];
        logic [W-1:0] exp_val;
        logic         err_exp = 1'b0;
        logic         rdy_before, acc, drn;
        int           sel;
        q.delete();
        b_valid = 1'b0;
        b_ready_in = 1'b0;
        for (int c = 0; c < 10020; c++) begin
            @(negedge clk);
            checks++;
            if (b_valid_o !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rnd_valid @%0d: valid=%b, want %0d", c, b_valid_o, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++;
                if (b_dout !== q[0]) begin
                    errors++;
                    $display("FAIL rnd_data @%0d: data=%h, want %h", c, b_dout, q[0]);
                end
            end
            checks++;
            if (b_ready !== (q.size() < 2)) begin
                errors++;
                $display("FAIL rnd_ready @%0d: ready=%b, want %0d", c, b_ready, q.size() < 2);
            end
`ifdef SEL_ERR_EN
            checks++;
            if (b_err !== err_exp) begin
                errors++;
                $display("FAIL rnd_err @%0d: err=%b, want %b", c, b_err, err_exp);
            end
`endif
            sel = 0;
            exp_val = '0;
            if (c < 10000) begin
                for (int k = 0; k < 5; k++) chans[k] = $urandom;
                b_data = {chans[4], chans[3], chans[2], chans[1], chans[0]};
                sel = int'($urandom_range(0, 7));
                b_sel = 3'(sel);
                exp_val = (sel < 5) ? chans[sel] : '0;
                b_valid = 1'($urandom_range(0, 1));
                rdy_before = b_ready;
                b_ready_in = 1'($urandom_range(0, 1));
            end else begin
                b_valid = 1'b0;
                rdy_before = b_ready;
                b_ready_in = 1'b1;
            end
            #1;
            checks++;
            if (b_ready !== rdy_before) begin
                errors++;
                $display("FAIL rnd_ready_comb @%0d: ready=%b, was %b", c, b_ready, rdy_before);
            end
            acc = b_valid & b_ready;
            drn = b_valid_o & b_ready_in;
            if (drn && q.size() != 0) void'(q.pop_front());
            if (acc) q.push_back(exp_val);
            if (acc && sel >= 5) err_exp = 1'b1;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain: %0d items left, want 0", q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_data = '0; a_sel = '0; a_valid = 1'b0; a_ready_in = 1'b0;
        b_data = '0; b_sel = '0; b_valid = 1'b0; b_ready_in = 1'b0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_reset_mid();
        test_sel_range();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
